ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_host_tx_if.sv | 28 ++
 rtl/ps2_sync_edge.sv | 34 +++
 rtl/ps2_host_tx.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and frame constants for the PS/2 host path.
// Used by the transmitter, its handshake interface and the bench.
package ps2_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    PARITY,
    STOP,
    ACK,
    WAIT_IDLE,
    FAIL
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int MAX_RETRY = 2;

  // Odd parity bit: set when the byte holds an even number of ones.
  function automatic logic odd_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between host logic and transmitter.
// master = command issuer, slave = ps2_host_tx.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_err;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done,
    output tx_err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for PS2_CLK/PS2_DATA and a
// falling-edge strobe on the synced clock; shared with the receive path.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_s,
  output logic data_s,
  output logic fe
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Lines idle released (high), so reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_pin};
      data_ff  <= {data_ff[0], data_pin};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  assign fe     = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Define PS2_TX_RETRY_EN to retry a failed frame up to MAX_RETRY times.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst_n,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  import ps2_pkg::*;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int XW = $clog2(DATA_BITS);

  localparam logic [IW-1:0] INH_LAST =
    IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [XW-1:0] IDX_LAST =
    XW'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nx;
  logic [DATA_BITS-1:0] dat_q;
  logic [DATA_BITS-1:0] dat_nx;
  logic [XW-1:0]        idx;
  logic [XW-1:0]        idx_nx;
  logic [IW-1:0]        inh_cnt;
  logic [IW-1:0]        inh_nx;
  logic [TW-1:0]        to_cnt;
  logic [TW-1:0]        to_nx;
  logic                 oe_q;
  logic                 oe_nx;
  logic                 done_q;
  logic                 done_nx;
  logic                 err_q;
  logic                 err_nx;

  logic clk_s;
  logic data_s;
  logic fe;
  logic active;
  logic timed_out;
  logic fail_hit;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
  logic [1:0] retry_nx;
`endif

  ps2_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_pin  (ps2_clk_in),
    .data_pin (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .fe       (fe)
  );

  // States where the device owns the clock and may stall us.
  assign active = state inside
    {RTS, SHIFT, PARITY, STOP, ACK, WAIT_IDLE};

  assign timed_out = active && !fe && (to_cnt == TO_LAST);

  // Next-state, frame sequencing and failure/retry decision.
  always_comb begin
    state_nx = state;
    dat_nx   = dat_q;
    idx_nx   = idx;
    inh_nx   = inh_cnt;
    to_nx    = to_cnt;
    oe_nx    = oe_q;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    fail_hit = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_nx = retry_cnt;
`endif

    if (active) begin
      to_nx = fe ? '0 : to_cnt + 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (tx.tx_start) begin
          state_nx = INHIBIT;
          dat_nx   = tx.tx_data;
          inh_nx   = '0;
`ifdef PS2_TX_RETRY_EN
          retry_nx = '0;
`endif
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          state_nx = RTS;
          oe_nx    = 1'b1;
          to_nx    = '0;
        end else begin
          inh_nx = inh_cnt + 1'b1;
        end
      end
      RTS: begin
        state_nx = SHIFT;
        idx_nx   = '0;
      end
      SHIFT: begin
        if (fe) begin
          oe_nx = ~dat_q[idx];
          if (idx == IDX_LAST) begin
            state_nx = PARITY;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (fe) begin
          oe_nx    = ~odd_parity(dat_q);
          state_nx = STOP;
        end
      end
      STOP: begin
        if (fe) begin
          oe_nx    = 1'b0;
          state_nx = ACK;
        end
      end
      ACK: begin
        if (fe) begin
          if (data_s) begin
            fail_hit = 1'b1;
          end else begin
            state_nx = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      FAIL: begin
        state_nx = IDLE;
        err_nx   = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        oe_nx    = 1'b0;
      end
    endcase

    // A finished handshake wins over a same-cycle timeout.
    if (timed_out && !done_nx) begin
      fail_hit = 1'b1;
    end

    if (fail_hit) begin
      oe_nx = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt < 2'(MAX_RETRY)) begin
        state_nx = INHIBIT;
        inh_nx   = '0;
        retry_nx = retry_cnt + 2'd1;
      end else begin
        state_nx = FAIL;
      end
`else
      state_nx = FAIL;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      dat_q   <= '0;
      idx     <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      dat_q   <= dat_nx;
      idx     <= idx_nx;
      inh_cnt <= inh_nx;
      to_cnt  <= to_nx;
      oe_q    <= oe_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Attempt counter for the current command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else begin
      retry_cnt <= retry_nx;
    end
  end
`endif

  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = oe_q;
  assign tx.tx_busy  = (state != IDLE);
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with an open-drain PS/2 device model.
// Frames are captured bit by bit on device clock rising edges.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 400;
  localparam int HP  = 12;

  logic clk;
  logic rst_n;
  logic host_clk_oe;
  logic host_data_oe;
  logic dev_clk_low;
  logic dev_data_low;
  logic clk_line;
  logic data_line;

  ps2_host_tx_if bus ();

  assign clk_line  = ~(host_clk_oe | dev_clk_low);
  assign data_line = ~(host_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx          (bus),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (host_clk_oe),
    .ps2_data_oe (host_data_oe)
  );

  int n_vec;
  int n_bad;
  int cyc;
  int done_cnt;
  int err_cnt;
  int busy_cyc;
  int inh_run;
  int inh_last;
  int dev_mode;
  int dev_fe;
  int dev_frames;
  logic dev_busy;
  logic [10:0] dev_bits;
  logic [10:0] dev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse/busy counters and clock-inhibit run length.
  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) err_cnt++;
    if (bus.tx_busy) busy_cyc++;
    if (host_clk_oe) begin
      inh_run++;
    end else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Device model: 0 = ACK, 1 = NACK, 2 = never clocks.
  initial begin
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    dev_busy     = 1'b0;
    forever begin
      @(negedge clk);
      if (dev_mode != 2 && rst_n && clk_line && !data_line) begin
        dev_busy = 1'b1;
        dev_fe   = 0;
        repeat (8) @(negedge clk);
        dev_bits[0] = data_line;
        for (int i = 1; i <= 11; i++) begin
          if (i == 11 && dev_mode == 0) dev_data_low = 1'b1;
          repeat (4) @(negedge clk);
          dev_clk_low = 1'b1;
          dev_fe      = i;
          repeat (HP) @(negedge clk);
          if (i <= 10) dev_bits[i] = data_line;
          dev_clk_low = 1'b0;
          repeat (HP) @(negedge clk);
        end
        dev_data_low = 1'b0;
        dev_last     = dev_bits;
        dev_frames++;
        dev_busy = 1'b0;
      end
    end
  end

  // Called at a negedge; start is sampled by the next posedge.
  task automatic send(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_data  = ~b;
    chk("accept_busy", bus.tx_busy, 1);
    chk("accept_clk_oe", host_clk_oe, 1);
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(bus.tx_done || bus.tx_err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("end_in_budget", n < budget, 1);
    chk("busy_low_at_end", bus.tx_busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_dev(input int budget);
    int n = 0;
    while (dev_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("dev_idle_in_budget", n < budget, 1);
  endtask

  task automatic wait_fe(input int k);
    int n = 0;
    while (!(dev_busy && dev_fe == k) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_fe", n < 2000, 1);
  endtask

  initial begin
    int d0, e0, f0, b0, t0, n;
    int exp_frames, exp_lat;
    n_vec = 0;
    n_bad = 0;
    dev_mode = 0;
    rst_n = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (4) @(negedge clk);
    chk("rst_clk_oe", host_clk_oe, 0);
    chk("rst_data_oe", host_data_oe, 0);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_done", bus.tx_done, 0);
    chk("rst_err", bus.tx_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    chk("ed_data_oe_inh", host_data_oe, 0);
    wait_end(2000);
    wait_dev(200);
    chk("ed_bits", dev_last, 11'h7DA);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_err", err_cnt - e0, 0);
    chk("ed_inhibit", inh_last, INH);
    chk("ed_busy_after", bus.tx_busy, 0);

    // 0x01 then 0xFF back to back
    d0 = done_cnt;
    send(8'h01);
    wait_end(2000);
    chk("b2b_01_bits", dev_last, 11'h402);
    chk("b2b_01_inhibit", inh_last, INH);
    send(8'hFF);
    wait_end(2000);
    wait_dev(200);
    chk("b2b_ff_bits", dev_last, 11'h7FE);
    chk("b2b_ff_inhibit", inh_last, INH);
    chk("b2b_done", done_cnt - d0, 2);

    // NACK on the 11th falling edge
`ifdef PS2_TX_RETRY_EN
    exp_frames = 3;
`else
    exp_frames = 1;
`endif
    dev_mode = 1;
    d0 = done_cnt; e0 = err_cnt; f0 = dev_frames;
    send(8'hED);
    wait_end(4000);
    chk("nack_clk_oe", host_clk_oe, 0);
    chk("nack_data_oe", host_data_oe, 0);
    wait_dev(200);
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_done", done_cnt - d0, 0);
    chk("nack_frames", dev_frames - f0, exp_frames);
    dev_mode = 0;

    // Device never clocks
`ifdef PS2_TX_RETRY_EN
    exp_lat = 3 * TO + 2 * INH + 1;
`else
    exp_lat = TO + 1;
`endif
    dev_mode = 2;
    e0 = err_cnt;
    send(8'h12);
    n = 0;
    while (!host_data_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_rts_seen", n < 100, 1);
    t0 = cyc;
    n = 0;
    while (!bus.tx_err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", cyc - t0, exp_lat);
    chk("to_clk_oe", host_clk_oe, 0);
    chk("to_data_oe", host_data_oe, 0);
    @(negedge clk);
    chk("to_err", err_cnt - e0, 1);
    dev_mode = 0;

    // tx_start while busy is dropped
    d0 = done_cnt;
    send(8'hF4);
    wait_fe(2);
    bus.tx_data  = 8'h55;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_end(2000);
    wait_dev(200);
    chk("busy_start_bits", dev_last, 11'h5E8);
    chk("busy_start_done", done_cnt - d0, 1);
    b0 = busy_cyc; f0 = dev_frames;
    repeat (60) @(negedge clk);
    chk("busy_start_no_busy", busy_cyc - b0, 0);
    chk("busy_start_no_frame", dev_frames - f0, 0);

    // Reset after the 4th falling edge
    send(8'h00);
    wait_fe(4);
    repeat (6) @(negedge clk);
    chk("mid_pre_data_oe", host_data_oe, 1);
    d0 = done_cnt; e0 = err_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_clk_oe", host_clk_oe, 0);
    chk("mid_data_oe", host_data_oe, 0);
    chk("mid_busy", bus.tx_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_dev(1000);
    repeat (10) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_no_err", err_cnt - e0, 0);
    send(8'hED);
    wait_end(2000);
    wait_dev(200);
    chk("mid_ed_bits", dev_last, 11'h7DA);
    chk("mid_ed_done", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
